// File: rtl/idu_issue_queue.sv
// Decode-to-issue in-order FIFO with valid/ready on both sides and flush of unissued entries.
// Optional same-cycle empty-queue bypass enabled by defining IDU_QUEUE_BYPASS_EN.
package idu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  fu_type;
    logic        illegal;
  } decoder_t;

endpackage

module idu_issue_queue
  import idu_pkg::*;
#(
  parameter  int Depth = 4,
  localparam int PtrW  = $clog2(Depth)
) (
  input  logic          clock,
  input  logic          reset,
  input  decoder_t      dec_instr,
  input  logic          dec_valid,
  output logic          dec_ready,
  output decoder_t      idu2isu_instr,
  output logic          idu_valid,
  input  logic          isu2idu_ready,
  input  logic          flush_unissued_instr,
  output logic [PtrW:0] occupancy
);

  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  decoder_t        mem [Depth];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW:0]   count;

  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;
  logic q_nonempty;

  assign q_nonempty = (count != '0);
  assign dec_ready  = (count != FullCnt);
  assign occupancy  = count;
  assign push       = dec_valid & dec_ready;
  assign pop        = idu_valid & isu2idu_ready;

`ifdef IDU_QUEUE_BYPASS_EN
  logic bypass_active;
  logic bypass_take;

  // Reset gates the bypass so idu_valid stays low while reset is held.
  assign bypass_active = ~q_nonempty & dec_valid & ~flush_unissued_instr & reset;
  assign bypass_take   = bypass_active & isu2idu_ready;
  assign idu_valid     = q_nonempty | bypass_active;

  always_comb begin
    idu2isu_instr = '0;
    if (q_nonempty)
      idu2isu_instr = mem[rd_ptr];
    else if (bypass_active)
      idu2isu_instr = dec_instr;
  end

  // A bypassed packet consumed this cycle is neither written nor read from storage.
  assign wr_en = push & ~bypass_take & ~flush_unissued_instr;
  assign rd_en = pop & ~bypass_take;
`else
  assign idu_valid = q_nonempty;

  always_comb begin
    idu2isu_instr = '0;
    if (q_nonempty)
      idu2isu_instr = mem[rd_ptr];
  end

  assign wr_en = push & ~flush_unissued_instr;
  assign rd_en = pop;
`endif

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_ptr] <= dec_instr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_unissued_instr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PtrW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + PtrW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PtrW + 1)'(1);
        2'b01:   count <= count - (PtrW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_idu_issue_queue.sv
// Self-checking bench for idu_issue_queue: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_idu_issue_queue;
  import idu_pkg::*;

  localparam int Depth = 4;
`ifdef IDU_QUEUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic     clock = 1'b0;
  logic     reset;
  decoder_t dec_instr;
  logic     dec_valid;
  logic     dec_ready;
  decoder_t idu2isu_instr;
  logic     idu_valid;
  logic     isu2idu_ready;
  logic     flush_unissued_instr;
  logic [2:0] occupancy;

  idu_issue_queue #(.Depth(Depth)) dut (
    .clock                (clock),
    .reset                (reset),
    .dec_instr            (dec_instr),
    .dec_valid            (dec_valid),
    .dec_ready            (dec_ready),
    .idu2isu_instr        (idu2isu_instr),
    .idu_valid            (idu_valid),
    .isu2idu_ready        (isu2idu_ready),
    .flush_unissued_instr (flush_unissued_instr),
    .occupancy            (occupancy)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  decoder_t    model_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic decoder_t mk_pc(input logic [31:0] pc);
    decoder_t d;
    d = '0;
    d.pc = pc;
    d.opcode = 7'h13;
    return d;
  endfunction

  function automatic decoder_t mk_rand();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[$bits(decoder_t)-1:0];
  endfunction

  // One clock: drive at negedge, check against the model, then advance the model at posedge.
  task automatic cycle(input bit v, input decoder_t d, input bit r, input bit f);
    int       n;
    bit       byp;
    bit       e_valid;
    bit       e_ready;
    decoder_t e_instr;
    @(negedge clock);
    dec_valid = v;
    dec_instr = d;
    isu2idu_ready = r;
    flush_unissued_instr = f;
    #1;
    n       = model_q.size();
    byp     = Byp && n == 0 && v && !f;
    e_valid = (n != 0) || byp;
    e_ready = (n != Depth);
    e_instr = (n != 0) ? model_q[0] : (byp ? d : '0);
    check("dec_ready", 64'(dec_ready), 64'(e_ready));
    check("idu_valid", 64'(idu_valid), 64'(e_valid));
    check("instr",     64'(idu2isu_instr), 64'(e_instr));
    check("occupancy", 64'(occupancy), 64'(n));
    @(posedge clock);
    if (f)
      model_q.delete();
    else if (!(byp && r)) begin
      if (e_valid && r) void'(model_q.pop_front());
      if (v && e_ready) model_q.push_back(d);
    end
  endtask

  task automatic async_reset();
    @(negedge clock);
    dec_valid = 1'b0;
    isu2idu_ready = 1'b0;
    flush_unissued_instr = 1'b0;
    #2;
    reset = 1'b0;
    model_q.delete();
    #1;
    check("rst_valid", 64'(idu_valid), 64'd0);
    check("rst_ready", 64'(dec_ready), 64'd1);
    check("rst_occ",   64'(occupancy), 64'd0);
    check("rst_instr", 64'(idu2isu_instr), 64'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int unsigned pv;
    int unsigned pr;
    reset = 1'b0;
    dec_valid = 1'b0;
    dec_instr = '0;
    isu2idu_ready = 1'b0;
    flush_unissued_instr = 1'b0;
    #1;
    check("init_valid", 64'(idu_valid), 64'd0);
    check("init_ready", 64'(dec_ready), 64'd1);
    check("init_occ",   64'(occupancy), 64'd0);
    #12;
    reset = 1'b1;

    // Fill to full with issue stalled, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1, mk_pc(32'h8000_0000 + 32'(4 * i)), 0, 0);
    cycle(1, mk_pc(32'hDEAD_0000), 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);

    // Hold occupancy at 2 with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 2; i++) cycle(1, mk_pc(32'h0000_1000 + 32'(4 * i)), 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, mk_pc(32'h0000_2000 + 32'(4 * i)), 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);

    // Full with pop and push in the same cycle.
    for (int i = 0; i < 4; i++) cycle(1, mk_pc(32'h0000_3000 + 32'(4 * i)), 0, 0);
    cycle(1, mk_pc(32'h0000_30F0), 1, 0);
    cycle(0, '0, 0, 0);

    // Flush with concurrent push and pop at occupancy 3.
    cycle(0, '0, 1, 0);
    cycle(1, mk_pc(32'h0000_4000), 0, 0);
    cycle(1, mk_pc(32'hBAD0_0000), 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);

    // Empty-queue push with issue ready (bypass case when enabled).
    cycle(1, mk_pc(32'h0000_0100), 1, 0);
    cycle(0, '0, 1, 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) cycle(1, mk_pc(32'h0000_5000 + 32'(4 * i)), 0, 0);
    async_reset();
    cycle(1, mk_pc(32'h0000_6000), 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);

    // Randomized traffic in phases with varying push/pop pressure.
    pv = 50;
    pr = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) begin
        pv = $urandom_range(95, 15);
        pr = $urandom_range(95, 15);
      end
      cycle($urandom_range(99, 0) < pv, mk_rand(),
            $urandom_range(99, 0) < pr, $urandom_range(99, 0) < 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
